// File: rtl/ahb_lite_interconnect_n.sv
// AHB-Lite single-master interconnect: address decoder, data-phase response mux and default slave.
// Optional stall watchdog enabled by defining AHB_TIMEOUT_EN (adds the HTIMEOUT port).
module ahb_lite_interconnect_n #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int NO_OF_SLAVES   = 4,
  parameter int P_BITS         = $clog2(NO_OF_SLAVES + 1),
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                             HCLK,
  input  logic                             HRESETn,
  input  logic [ADDR_WIDTH-1:0]            HADDR,
  input  logic [1:0]                       HTRANS,
  output logic [DATA_WIDTH-1:0]            HRDATA,
  output logic [1:0]                       HRESP,
  output logic                             HREADY,
`ifdef AHB_TIMEOUT_EN
  output logic                             HTIMEOUT,
`endif
  output logic [NO_OF_SLAVES-1:0]          HSEL_S,
  input  logic [NO_OF_SLAVES*DATA_WIDTH-1:0] HRDATA_S,
  input  logic [2*NO_OF_SLAVES-1:0]        HRESP_S,
  input  logic [NO_OF_SLAVES-1:0]          HREADYOUT_S
);

  localparam logic [P_BITS-1:0] DEF_SEL    = P_BITS'(NO_OF_SLAVES);
  localparam logic [1:0]        RESP_OKAY  = 2'b00;
  localparam logic [1:0]        RESP_ERROR = 2'b01;

  typedef enum logic [1:0] {DS_OK, DS_ERR1, DS_ERR2} ds_state_t;

  logic [P_BITS-1:0]     region;
  logic [P_BITS-1:0]     dec_sel;
  logic                  dec_default;
  logic [P_BITS-1:0]     dsel;
  ds_state_t             ds_state, ds_next;
  logic [DATA_WIDTH-1:0] mux_rdata;
  logic [1:0]            mux_resp;
  logic                  mux_ready;
  logic                  unused_ok;

  // Only the region field and the NONSEQ/SEQ bit take part in routing.
  assign unused_ok = ^{HTRANS[0], HADDR[ADDR_WIDTH-P_BITS-1:0]};

  assign region      = HADDR[ADDR_WIDTH-1 -: P_BITS];
  assign dec_default = (region >= DEF_SEL);
  assign dec_sel     = dec_default ? DEF_SEL : region;

  // NOTE: every signal written in an always_comb gets a value before any branch, so no latch is inferred.
  always_comb begin
    HSEL_S = '0;
    for (int i = 0; i < NO_OF_SLAVES; i++) begin
      HSEL_S[i] = (region == P_BITS'(i));
    end
  end

  // NOTE: state registers use non-blocking assignments and a synchronous active-low reset.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      dsel     <= DEF_SEL;
      ds_state <= DS_OK;
    end else begin
      ds_state <= ds_next;
      if (HREADY) begin
        dsel <= dec_sel;
      end
    end
  end

  // Default slave: two-cycle ERROR for any real transfer into unmapped space.
  always_comb begin
    ds_next = ds_state;
    case (ds_state)
      DS_OK:   if (HREADY && dec_default && HTRANS[1]) ds_next = DS_ERR1;
      DS_ERR1: ds_next = DS_ERR2;
      DS_ERR2: ds_next = (dec_default && HTRANS[1]) ? DS_ERR1 : DS_OK;
      default: ds_next = DS_OK;
    endcase
  end

  // The mux follows the registered data-phase select, never the live decode.
  always_comb begin
    mux_rdata = '0;
    mux_resp  = RESP_OKAY;
    mux_ready = 1'b1;
    for (int i = 0; i < NO_OF_SLAVES; i++) begin
      if (dsel == P_BITS'(i)) begin
        mux_rdata = HRDATA_S[i*DATA_WIDTH +: DATA_WIDTH];
        mux_resp  = HRESP_S[2*i +: 2];
        mux_ready = HREADYOUT_S[i];
      end
    end
    if (dsel >= DEF_SEL) begin
      mux_ready = (ds_state != DS_ERR1);
      mux_resp  = (ds_state == DS_OK) ? RESP_OKAY : RESP_ERROR;
    end
  end

  assign HRDATA = mux_rdata;

`ifdef AHB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] to_cnt;
  logic             dactive;
  logic             stall;
  logic             to_err1;
  logic             to_err2;

  assign stall   = dactive && (dsel < DEF_SEL) && !mux_ready;
  assign to_err1 = (to_cnt == CNT_W'(TIMEOUT_CYCLES));

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      dactive <= 1'b0;
      to_cnt  <= '0;
      to_err2 <= 1'b0;
    end else begin
      to_err2 <= to_err1;
      if (HREADY) begin
        dactive <= HTRANS[1];
      end
      if (to_err1 || to_err2 || !stall) begin
        to_cnt <= '0;
      end else begin
        to_cnt <= to_cnt + 1'b1;
      end
    end
  end

  // The watchdog response overrides whatever the stalled slave drives.
  assign HREADY   = to_err1 ? 1'b0 : (to_err2 ? 1'b1 : mux_ready);
  assign HRESP    = (to_err1 || to_err2) ? RESP_ERROR : mux_resp;
  assign HTIMEOUT = to_err1;
`else
  localparam int UNUSED_TIMEOUT = TIMEOUT_CYCLES;

  assign HREADY = mux_ready;
  assign HRESP  = mux_resp;
`endif

endmodule

// File: tb/tb_ahb_lite_interconnect_n.sv
// Bench for ahb_lite_interconnect_n (N=4): directed stimulus, behavioural model compared every cycle,
// plus hand-computed literal expectations.
module tb_ahb_lite_interconnect_n;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int N  = 4;
  localparam int PB = 3;
`ifdef AHB_TIMEOUT_EN
  localparam int TO = 4;
`else
  localparam int TO = 16;
`endif

  logic            HCLK = 1'b0;
  logic            HRESETn;
  logic [AW-1:0]   HADDR;
  logic [1:0]      HTRANS;
  logic [DW-1:0]   HRDATA;
  logic [1:0]      HRESP;
  logic            HREADY;
  logic [N-1:0]    HSEL_S;
  logic [N*DW-1:0] HRDATA_S;
  logic [2*N-1:0]  HRESP_S;
  logic [N-1:0]    HREADYOUT_S;
`ifdef AHB_TIMEOUT_EN
  logic            HTIMEOUT;
`endif

  ahb_lite_interconnect_n #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NO_OF_SLAVES(N), .P_BITS(PB), .TIMEOUT_CYCLES(TO)
  ) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HADDR(HADDR), .HTRANS(HTRANS),
    .HRDATA(HRDATA), .HRESP(HRESP), .HREADY(HREADY),
`ifdef AHB_TIMEOUT_EN
    .HTIMEOUT(HTIMEOUT),
`endif
    .HSEL_S(HSEL_S), .HRDATA_S(HRDATA_S), .HRESP_S(HRESP_S), .HREADYOUT_S(HREADYOUT_S)
  );

  always #5 HCLK = ~HCLK;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: which target owns the data phase, and where the error/timeout sequences stand.
  int m_tgt   = N;
  bit m_act   = 1'b0;
  int m_def   = 0;   // 0 none, 1 first ERROR cycle, 2 second ERROR cycle
  int m_stall = 0;
  int m_to    = 0;   // 0 none, 1 timeout pulse cycle, 2 closing ERROR cycle
  bit m_valid = 1'b0;

  function automatic int decode(input logic [31:0] a);
    int r;
    r = int'(a >> (AW - PB));
    return (r < N) ? r : N;
  endfunction

  function automatic logic [N-1:0] exp_hsel(input logic [31:0] a);
    int d;
    d = decode(a);
    exp_hsel = '0;
    if (d < N) exp_hsel[d] = 1'b1;
  endfunction

  function automatic void expect_out(output logic [31:0] rd, output logic [1:0] rs,
                                     output logic rdy, output logic tp);
    rd = '0; rs = 2'b00; rdy = 1'b1; tp = 1'b0;
    if (m_tgt < N) begin
      rd  = HRDATA_S[m_tgt*DW +: DW];
      rs  = HRESP_S[2*m_tgt +: 2];
      rdy = HREADYOUT_S[m_tgt];
    end else begin
      rdy = (m_def != 1);
      rs  = (m_def != 0) ? 2'b01 : 2'b00;
    end
    if (m_to == 1) begin
      rdy = 1'b0; rs = 2'b01; tp = 1'b1;
    end else if (m_to == 2) begin
      rdy = 1'b1; rs = 2'b01;
    end
  endfunction

  always @(posedge HCLK) begin : model_update
    logic [31:0] e_rd;
    logic [1:0]  e_rs;
    logic        e_rdy, e_tp;
    expect_out(e_rd, e_rs, e_rdy, e_tp);
    if (!HRESETn) begin
      m_valid <= 1'b1;
      m_tgt   <= N;
      m_act   <= 1'b0;
      m_def   <= 0;
      m_stall <= 0;
      m_to    <= 0;
    end else begin
      if (e_rdy) begin
        m_tgt <= decode(HADDR);
        m_act <= HTRANS[1];
      end
      if (m_def == 1)                                   m_def <= 2;
      else if (e_rdy && decode(HADDR) == N && HTRANS[1]) m_def <= 1;
      else                                              m_def <= 0;
`ifdef AHB_TIMEOUT_EN
      if (m_to == 1) begin
        m_to <= 2; m_stall <= 0;
      end else if (m_to == 2) begin
        m_to <= 0;
      end else if (m_act && m_tgt < N && !HREADYOUT_S[m_tgt]) begin
        m_stall <= m_stall + 1;
        if (m_stall + 1 == TO) m_to <= 1;
      end else begin
        m_stall <= 0;
      end
`endif
    end
  end

  always @(negedge HCLK) begin : compare
    logic [31:0] e_rd;
    logic [1:0]  e_rs;
    logic        e_rdy, e_tp;
    if (m_valid) begin
      expect_out(e_rd, e_rs, e_rdy, e_tp);
      check("model_hready", 64'(HREADY), 64'(e_rdy));
      check("model_hresp",  64'(HRESP),  64'(e_rs));
      check("model_hrdata", 64'(HRDATA), 64'(e_rd));
      check("model_hsel",   64'(HSEL_S), 64'(exp_hsel(HADDR)));
`ifdef AHB_TIMEOUT_EN
      check("model_htimeout", 64'(HTIMEOUT), 64'(e_tp));
`endif
    end
  end

  // One bus cycle: inputs change just after the rising edge, the caller checks at the falling edge.
  task automatic drive(input logic [31:0] a, input logic [1:0] t, input logic [N-1:0] rdyo,
                       input logic rst_n);
    @(posedge HCLK);
    #1;
    HADDR = a; HTRANS = t; HREADYOUT_S = rdyo; HRESETn = rst_n;
    @(negedge HCLK);
  endtask

  task automatic expect_bus(input string name, input logic rdy, input logic [1:0] rs,
                            input logic [31:0] rd);
    check({name, "_hready"}, 64'(HREADY), 64'(rdy));
    check({name, "_hresp"},  64'(HRESP),  64'(rs));
    check({name, "_hrdata"}, 64'(HRDATA), 64'(rd));
  endtask

  localparam logic [1:0] IDLE = 2'b00, NSEQ = 2'b10, SEQ = 2'b11;
  localparam logic [N-1:0] ALL = 4'b1111;

  initial begin
    HRESETn     = 1'b0;
    HADDR       = 32'h8000_0000;
    HTRANS      = IDLE;
    HREADYOUT_S = ALL;
    HRESP_S     = 8'b01_00_00_00;
    HRDATA_S    = {32'h3333_3333, 32'hDEAD_BEEF, 32'h1111_1111, 32'h0000_AAAA};

    // Reset held for two edges
    drive(32'h8000_0000, IDLE, ALL, 1'b0);
    expect_bus("reset", 1'b1, 2'b00, 32'h0);
    check("reset_hsel", 64'(HSEL_S), 64'(0));
    drive(32'h8000_0000, IDLE, ALL, 1'b0);

    // Read from slave 2
    drive(32'h4000_0010, NSEQ, ALL, 1'b1);
    check("rd_s2_hsel", 64'(HSEL_S), 64'(4'b0100));
    drive(32'h8000_0000, IDLE, ALL, 1'b1);
    expect_bus("rd_s2_data", 1'b1, 2'b00, 32'hDEAD_BEEF);

    // Default region, single NONSEQ
    drive(32'h8000_0000, NSEQ, ALL, 1'b1);
    expect_bus("def_idle_ok", 1'b1, 2'b00, 32'h0);
    drive(32'h0000_0000, IDLE, ALL, 1'b1);
    expect_bus("def_err1", 1'b0, 2'b01, 32'h0);
    drive(32'h0000_0000, IDLE, ALL, 1'b1);
    expect_bus("def_err2", 1'b1, 2'b01, 32'h0);

    // Region wrap (7) then back-to-back default transfers (region 5)
    drive(32'hE000_0000, SEQ, ALL, 1'b1);
    expect_bus("def_then_ok", 1'b1, 2'b00, 32'h0000_AAAA);
    drive(32'hA000_0000, NSEQ, ALL, 1'b1);
    expect_bus("wrap_err1", 1'b0, 2'b01, 32'h0);
    drive(32'hA000_0000, NSEQ, ALL, 1'b1);
    expect_bus("wrap_err2", 1'b1, 2'b01, 32'h0);
    drive(32'h2000_0000, IDLE, ALL, 1'b1);
    expect_bus("b2b_err1", 1'b0, 2'b01, 32'h0);
    drive(32'h2000_0000, IDLE, ALL, 1'b1);
    expect_bus("b2b_err2", 1'b1, 2'b01, 32'h0);

    // Wait states on slave 0 while slave 1 address is pending
    drive(32'h0000_0004, NSEQ, ALL, 1'b1);
    expect_bus("s1_idle", 1'b1, 2'b00, 32'h1111_1111);
    for (int i = 0; i < 3; i++) begin
      drive(32'h2000_0008, NSEQ, 4'b1110, 1'b1);
      expect_bus("ws_stall", 1'b0, 2'b00, 32'h0000_AAAA);
      check("ws_hsel", 64'(HSEL_S), 64'(4'b0010));
    end
    drive(32'h2000_0008, NSEQ, ALL, 1'b1);
    expect_bus("ws_done", 1'b1, 2'b00, 32'h0000_AAAA);
    drive(32'h6000_0000, NSEQ, ALL, 1'b1);
    expect_bus("ws_next_s1", 1'b1, 2'b00, 32'h1111_1111);

    // Slave 3 response passes through, then reset during the first ERROR cycle
    drive(32'h8000_0000, NSEQ, ALL, 1'b1);
    expect_bus("s3_resp", 1'b1, 2'b01, 32'h3333_3333);
    drive(32'h0000_0000, IDLE, ALL, 1'b0);
    expect_bus("rst_in_err1", 1'b0, 2'b01, 32'h0);
    drive(32'h0000_0000, IDLE, ALL, 1'b1);
    expect_bus("rst_after", 1'b1, 2'b00, 32'h0);
    drive(32'h0000_0000, IDLE, ALL, 1'b1);
    expect_bus("rst_no_err2", 1'b1, 2'b00, 32'h0000_AAAA);

`ifdef AHB_TIMEOUT_EN
    // Slave 1 stalls past the watchdog limit
    drive(32'h2000_0000, NSEQ, ALL, 1'b1);
    for (int i = 0; i < TO; i++) begin
      drive(32'h0000_0000, IDLE, 4'b1101, 1'b1);
      expect_bus("to_stall", 1'b0, 2'b00, 32'h1111_1111);
      check("to_stall_pulse", 64'(HTIMEOUT), 64'(0));
    end
    drive(32'h0000_0000, IDLE, 4'b1101, 1'b1);
    expect_bus("to_err1", 1'b0, 2'b01, 32'h1111_1111);
    check("to_pulse", 64'(HTIMEOUT), 64'(1));
    drive(32'h0000_0000, IDLE, 4'b1101, 1'b1);
    expect_bus("to_err2", 1'b1, 2'b01, 32'h1111_1111);
    check("to_pulse_end", 64'(HTIMEOUT), 64'(0));
    drive(32'h0000_0000, IDLE, ALL, 1'b1);
    expect_bus("to_recover", 1'b1, 2'b00, 32'h0000_AAAA);
`endif

    drive(32'h0000_0000, IDLE, ALL, 1'b1);
    drive(32'h0000_0000, IDLE, ALL, 1'b1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
